minirisc_cycle_seq: RTL
=======================

// Module: minirisc_cycle_seq
// PURPOSE
//  Multi-cycle sequencer for the MiniRISC core: steps the datapath through FETCH/DECODE/EXEC/MEM/WB and
//  issues per-stage enables (IR load, ALU, memory, regfile write, PC update). Shares one memory port
//  between instruction fetch and data access using a req/ack handshake with a timeout.
//  Provides run/single-step/halt control for board debugging. Sits beside main_control and consumes its decoded flags.
// PARAMETERS
//  HALT_OPCODE  4'hF  opcode that stops the sequencer in HALT
//  TO_W         8     width of the memory-timeout counter
//  MEM_TIMEOUT  200   cycles of mem_req without mem_ack before ERR; 0 disables timeout
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  run        in   1   level: 1 = free-run, 0 = single-step mode
//  step       in   1   one-cycle pulse (synchronised upstream): execute exactly one instruction when idle
//  opcode     in   4   opcode of the instruction register
//  mem_read   in   1   decoded MemRead of the current instruction
//  mem_write  in   1   decoded MemWrite of the current instruction
//  reg_write  in   1   current instruction writes the regfile (WriteReg != 0)
//  mem_ack    in   1   memory completed the current request this cycle
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   request is a write (valid with mem_req)
//  addr_sel   out  1   memory address source: 0 = PC (fetch), 1 = ALU result (data)
//  ir_load    out  1   load instruction register
//  alu_en     out  1   capture ALU result/flags
//  rf_we      out  1   regfile write strobe
//  pc_we      out  1   PC update strobe
//  state      out  3   current state encoding (debug display)
//  halted     out  1   sequencer is in HALT
//  error      out  1   sequencer is in ERR
//  cycle_cnt  out  32  cycles since reset outside IDLE/HALT/ERR (perf feature)
//  instr_cnt  out  32  instructions retired (perf feature)
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7. Reset: state=IDLE, counters=0, all outputs 0.
//  - IDLE: all strobes 0; -> FETCH if run | step; otherwise stay.
//  - FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ack: ir_load=1 (same cycle, Mealy), -> DECODE.
//  - DECODE: 1 cycle, no strobes; opcode==HALT_OPCODE -> HALT, else -> EXEC.
//  - EXEC: alu_en=1 for 1 cycle; -> MEM if mem_read|mem_write, else -> WB.
//  - MEM: mem_req=1, addr_sel=1, mem_we=mem_write; on mem_ack -> WB. mem_read&mem_write both set: treated as write.
//  - WB: rf_we=reg_write, pc_we=1, instr_cnt++; -> FETCH if run, else -> IDLE (step mode).
//  - HALT: sticky; only rst leaves. ERR: sticky; only rst leaves. No strobes in either.
//  - Timeout: counter clears on entering FETCH/MEM and on mem_ack, increments each cycle mem_req=1 without ack;
//    count reaching MEM_TIMEOUT-1 with no ack -> ERR next cycle (mem_req drops). Saturates, never wraps.
//  - Minimum latency per instruction: 4 cycles (ack in first FETCH cycle, no MEM); 5 with MEM.
//  - step while not IDLE is ignored; run deasserted mid-instruction completes that instruction then IDLE.
//  - mem_ack outside FETCH/MEM is ignored. rst mid-request: mem_req drops next edge, no strobes.
//  - cycle_cnt/instr_cnt wrap modulo 2^32.
// CONFIGURATION
//  - MINIRISC_SEQ_PERF_EN defined: cycle_cnt and instr_cnt implemented as above.
//  - Not defined: both ports tied to 32'd0, no counter flops; all other behaviour identical.
// STRUCTURE
//  - Shared include minirisc_seq_defs.vh: state encodings (S_IDLE..S_ERR), state width, HALT_OPCODE default;
//    shared with the top-level debug display logic.
//  - One sub-module: mem_timeout_cnt (clear, inc, limit -> expired), instantiated once.
//  - Single state register plus next-state/output combinational block in minirisc_cycle_seq.
// TESTING
//  - Free-run, ack in 1st cycle, ALU op (reg_write=1): FETCH,DECODE,EXEC,WB repeat; rf_we+pc_we every 4th cycle.
//  - Load (mem_read=1), mem_ack delayed 3 cycles in MEM: mem_req held 3 cycles, addr_sel=1, mem_we=0, then WB.
//  - run=0, step pulse: exactly one instruction, back to IDLE; step pulse during EXEC ignored.
//  - opcode=4'hF fetched: DECODE->HALT, halted=1, no pc_we; run/step/mem_ack ignored until rst.
//  - MEM_TIMEOUT=5, no mem_ack in FETCH: ERR after 5 request cycles, error=1, mem_req=0; rst -> IDLE.
//  - With MINIRISC_SEQ_PERF_EN: 3 ALU instrs from reset -> instr_cnt=3, cycle_cnt=12; without: both 0.

Source files
------------

// File: rtl/minirisc_cycle_seq_pkg.sv
// Shared definitions for the MiniRISC multi-cycle sequencer: state encodings and defaults.
// Also consumed by the top-level debug display logic.
package minirisc_cycle_seq_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/minirisc_cycle_seq_mem_timeout_cnt.sv
// Saturating request-wait counter; flags expiry on the last allowed cycle without an ack.
// A limit of 0 disables expiry.
module mem_timeout_cnt #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            inc,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] count;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = inc && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/minirisc_cycle_seq.sv
// MiniRISC multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, shared memory port, run/step/halt.
// Optional perf counters are built only when MINIRISC_SEQ_PERF_EN is defined.
module minirisc_cycle_seq
    import minirisc_cycle_seq_pkg::*;
#(
    parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int         TO_W        = 8,
    parameter int         MEM_TIMEOUT = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         step,
    input  logic [3:0]   opcode,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic         reg_write,
    input  logic         mem_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic         addr_sel,
    output logic         ir_load,
    output logic         alu_en,
    output logic         rf_we,
    output logic         pc_we,
    output logic [2:0]   state,
    output logic         halted,
    output logic         error,
    output logic [31:0]  cycle_cnt,
    output logic [31:0]  instr_cnt
);

    state_t cur, nxt;
    logic   to_expired;

    always_ff @(posedge clk) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves nxt unassigned (no latch).
        nxt = cur;
        unique case (cur)
            S_IDLE:   if (run || step) nxt = S_FETCH;
            S_FETCH:  if (mem_ack) nxt = S_DECODE;
                      else if (to_expired) nxt = S_ERR;
            S_DECODE: nxt = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC:   nxt = (mem_read || mem_write) ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) nxt = S_WB;
                      else if (to_expired) nxt = S_ERR;
            S_WB:     nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   nxt = S_HALT;
            S_ERR:    nxt = S_ERR;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
            end
            S_EXEC:  alu_en = 1'b1;
            // A read+write decode is issued as a write.
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = mem_write;
            end
            S_WB: begin
                rf_we = reg_write;
                pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);
    assign error  = (cur == S_ERR);

    // Counter is held clear whenever no request is pending, so each FETCH/MEM starts at zero.
    mem_timeout_cnt #(
        .TO_W(TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!mem_req || mem_ack),
        .inc     (mem_req && !mem_ack),
        .limit   (TO_W'(MEM_TIMEOUT)),
        .expired (to_expired)
    );

`ifdef MINIRISC_SEQ_PERF_EN
    logic [31:0] cycle_q, instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (!(cur inside {S_IDLE, S_HALT, S_ERR})) cycle_q <= cycle_q + 1'b1;
            if (cur == S_WB)                            instr_q <= instr_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule
